bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter in front of the Bridge.
- Master 0 is the CPU data port. Master 1 is a secondary requester such as a DMA or debug loader.
- Each master gets a req/ack handshake. Each granted transaction is sequenced onto the Bridge's single address/wdata/wen/rdata port.
- Includes round-robin fairness, a bounded lock for master-1 bursts, and a configurable read latency.

---
 rtl/bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master arbiter sequencing CPU (m0) and DMA/debug (m1) transactions onto one Bridge port.
// Latency: write ack 2 cycles after the IDLE sample, read ack 2+READ_LAT cycles after it.
// Backpressure: req/ack handshake; a requester simply waits (req held) until it is granted.
//
// Ports:
//   cpu_clk, cpu_rst            clock, synchronous active-high reset
//   m0_req/addr/wen/wdata       master 0 request side;  m0_ack, m0_rdata completion side
//   m1_req/addr/wen/wdata/lock  master 1 request side;  m1_ack, m1_rdata completion side
//   gnt                         one-hot current owner (bit0=m0, bit1=m1), 0 when idle
//   Bus_addr/wen/wdata/rdata    single Bridge port
module bus_arbiter #(
  parameter int READ_LAT = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [1:0]  gnt,
  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT);
  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic        r_owner;       // 0 = m0, 1 = m1
  logic        r_wen;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic        r_bus_wen;
  logic        r_m0_ack;
  logic        r_m1_ack;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        r_last_owner;
  logic [3:0]  r_lock_cnt;
  logic [2:0]  r_lat_cnt;

  logic        w_any_req;
  logic        w_lock_hold;
  logic        w_pick_m1;
  logic        w_done;
  logic [31:0] w_cap_dat;

  assign w_any_req   = m0_req | m1_req;
  // m1 keeps the bus across a tie only right after its own transaction and while lock budget remains.
  assign w_lock_hold = m1_lock & r_last_owner & (r_lock_cnt < LOCK_MAX);
  // m1 wins if alone, if m0 owned last (round-robin), or if holding the lock.
  assign w_pick_m1   = m1_req & (~m0_req | ~r_last_owner | w_lock_hold);

  // The transaction completes on this edge: writes and zero-latency reads leave ACCESS
  // directly, otherwise the final WAIT cycle captures the read data.
  assign w_done    = ((r_state == S_ACCESS) && (r_wen || (READ_LAT == 0))) ||
                     ((r_state == S_WAIT) && (r_lat_cnt == 3'd1));
  assign w_cap_dat = r_wen ? 32'h0 : Bus_rdata;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state      <= S_IDLE;
      r_gnt        <= 2'b00;
      r_owner      <= 1'b0;
      r_wen        <= 1'b0;
      r_bus_addr   <= 32'h0;
      r_bus_wdata  <= 32'h0;
      r_bus_wen    <= 1'b0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= 32'h0;
      r_m1_rdata   <= 32'h0;
      r_last_owner <= 1'b1;
      r_lock_cnt   <= 4'd0;
      r_lat_cnt    <= 3'd0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            // Bus_addr/Bus_wdata double as the latched request; they are driven in ACCESS.
            r_owner     <= w_pick_m1;
            r_gnt       <= w_pick_m1 ? 2'b10 : 2'b01;
            r_wen       <= w_pick_m1 ? m1_wen : m0_wen;
            r_bus_wen   <= w_pick_m1 ? m1_wen : m0_wen;
            r_bus_addr  <= w_pick_m1 ? m1_addr : m0_addr;
            r_bus_wdata <= w_pick_m1 ? m1_wdata : m0_wdata;
            r_state     <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          r_bus_wen <= 1'b0;
          if (w_done) begin
            r_state <= S_RESP;
          end else begin
            r_lat_cnt <= LAT_LOAD;
            r_state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (w_done) begin
            r_lat_cnt <= 3'd0;
            r_state   <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end

        S_RESP: begin
          r_last_owner <= r_owner;
          if (r_owner && m1_lock) begin
            if (r_lock_cnt != LOCK_MAX) begin
              r_lock_cnt <= r_lock_cnt + 4'd1;
            end
          end else begin
            r_lock_cnt <= 4'd0;
          end
          r_gnt       <= 2'b00;
          r_bus_addr  <= 32'h0;
          r_bus_wdata <= 32'h0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase

      // Ack and data land together in RESP; the non-owner's rdata is left untouched.
      if (w_done) begin
        if (r_owner) begin
          r_m1_ack   <= 1'b1;
          r_m1_rdata <= w_cap_dat;
        end else begin
          r_m0_ack   <= 1'b1;
          r_m0_rdata <= w_cap_dat;
        end
      end
    end
  end

  assign gnt       = r_gnt;
  assign Bus_addr  = r_bus_addr;
  assign Bus_wen   = r_bus_wen;
  assign Bus_wdata = r_bus_wdata;
  assign m0_ack    = r_m0_ack;
  assign m1_ack    = r_m1_ack;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed steps, acks checked against a queue of expected completions.
// Instance u_dut runs READ_LAT=1/MAX_LOCK=4; instance u_dut0 runs READ_LAT=0.
// Bus_rdata of u_dut0 follows the cycle counter so the capture cycle is observable.
module tb_bus_arbiter;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] mst;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] t0, t1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // main instance
  logic        rst, m0_req, m0_wen, m1_req, m1_wen, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
  logic        m0_ack, m1_ack, bus_wen;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  logic [1:0]  gnt;

  // zero-latency instance
  logic        z_rst, z_m0_req;
  logic [31:0] z_m0_addr, z_bus_rdata;
  logic        z_m0_ack, z_m1_ack, z_bus_wen;
  logic [31:0] z_m0_rdata, z_m1_rdata, z_bus_addr, z_bus_wdata;
  logic [1:0]  z_gnt;

  assign z_bus_rdata = 32'hC0DE_0000 ^ cyc;

  bus_arbiter #(.READ_LAT(1), .MAX_LOCK(4)) u_dut (
    .cpu_clk(clk), .cpu_rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .gnt(gnt), .Bus_addr(bus_addr), .Bus_wen(bus_wen), .Bus_wdata(bus_wdata),
    .Bus_rdata(bus_rdata)
  );

  bus_arbiter #(.READ_LAT(0), .MAX_LOCK(4)) u_dut0 (
    .cpu_clk(clk), .cpu_rst(z_rst),
    .m0_req(z_m0_req), .m0_addr(z_m0_addr), .m0_wen(1'b0), .m0_wdata(32'h0),
    .m0_ack(z_m0_ack), .m0_rdata(z_m0_rdata),
    .m1_req(1'b0), .m1_addr(32'h0), .m1_wen(1'b0), .m1_wdata(32'h0),
    .m1_lock(1'b0), .m1_ack(z_m1_ack), .m1_rdata(z_m1_rdata),
    .gnt(z_gnt), .Bus_addr(z_bus_addr), .Bus_wen(z_bus_wen), .Bus_wdata(z_bus_wdata),
    .Bus_rdata(z_bus_rdata)
  );

  logic [1:0]  ackv [2];
  logic [1:0]  gntv [2];
  logic [31:0] rdv  [2][2];
  assign ackv[0] = {m1_ack, m0_ack};
  assign ackv[1] = {z_m1_ack, z_m0_ack};
  assign gntv[0] = gnt;
  assign gntv[1] = z_gnt;
  assign rdv[0][0] = m0_rdata;
  assign rdv[0][1] = m1_rdata;
  assign rdv[1][0] = z_m0_rdata;
  assign rdv[1][1] = z_m1_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle after the last expected ack has been consumed.
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (sb.size() != 0 && n < budget);
    chk("drain_pending", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Completion monitor plus per-cycle structural invariants.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      chk("gnt_onehot0", {31'd0, $onehot0(gntv[i])}, 32'd1);
      chk("acks_exclusive", {31'd0, &ackv[i]}, 32'd0);
      for (int m = 0; m < 2; m++) begin
        if (ackv[i][m]) begin
          chk("ack_expected", {31'd0, (sb.size() != 0)}, 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ack_inst", 32'(i), e.inst);
            chk("ack_master", 32'(m), e.mst);
            chk("ack_rdata", rdv[i][m], e.rdata);
            chk("ack_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; z_rst = 1'b1;
    m0_req = 1'b0; m0_wen = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_wen = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_lock = 1'b0;
    bus_rdata = 32'h0;
    z_m0_req = 1'b0; z_m0_addr = 32'h0;
    tick();
    tick();
    rst = 1'b0; z_rst = 1'b0;

    // reset state
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rst_bus_wen", {31'd0, bus_wen}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);

    // m0 write: Bus_wen at T+1 only, ack at T+2
    tick();
    m0_req = 1'b1; m0_addr = 32'h0000_0010; m0_wen = 1'b1; m0_wdata = 32'hDEAD_BEEF;
    t0 = cyc;
    sb.push_back('{32'd0, 32'd0, 32'h0, t0 + 32'd2});
    chk("wr_T_wen", {31'd0, bus_wen}, 32'd0);
    tick();
    chk("wr_T1_gnt", {30'd0, gnt}, 32'd1);
    chk("wr_T1_wen", {31'd0, bus_wen}, 32'd1);
    chk("wr_T1_addr", bus_addr, 32'h10);
    chk("wr_T1_wdata", bus_wdata, 32'hDEAD_BEEF);
    tick();
    chk("wr_T2_wen", {31'd0, bus_wen}, 32'd0);
    tick();
    m0_req = 1'b0; m0_wen = 1'b0;
    chk("wr_T3_gnt", {30'd0, gnt}, 32'd0);
    chk("wr_T3_wen", {31'd0, bus_wen}, 32'd0);
    chk("wr_T3_addr", bus_addr, 32'd0);

    // m1 read, one cycle of latency, data valid only in the WAIT cycle
    tick();
    m1_req = 1'b1; m1_addr = 32'h20; m1_wen = 1'b0; bus_rdata = 32'hBAD0_BAD0;
    t0 = cyc;
    sb.push_back('{32'd0, 32'd1, 32'h1234_5678, t0 + 32'd3});
    tick();
    chk("rd_access_gnt", {30'd0, gnt}, 32'd2);
    chk("rd_access_wen", {31'd0, bus_wen}, 32'd0);
    chk("rd_access_addr", bus_addr, 32'h20);
    tick();
    bus_rdata = 32'h1234_5678;
    chk("rd_wait_addr", bus_addr, 32'h20);
    chk("rd_wait_wen", {31'd0, bus_wen}, 32'd0);
    tick();
    bus_rdata = 32'hBAD0_BAD0;
    chk("rd_resp_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("rd_resp_m0_rdata", m0_rdata, 32'd0);
    tick();
    m1_req = 1'b0;

    // both request continuously, no lock: strict alternation starting with m0
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h100; m0_wen = 1'b1; m0_wdata = 32'hA0;
    m1_req = 1'b1; m1_addr = 32'h200; m1_wen = 1'b1; m1_wdata = 32'hB1; m1_lock = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 4; k++)
      sb.push_back('{32'd0, 32'(k % 2), 32'h0, t0 + 32'(3 * k + 2)});
    wait_drain(40);
    m0_req = 1'b0; m1_req = 1'b0;

    // lock: m0, m1 (round-robin, unlocked), then 4 locked m1 grants, then m0
    tick();
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m1_lock = 1'b0;
    t0 = cyc;
    sb.push_back('{32'd0, 32'd0, 32'h0, t0 + 32'd2});
    sb.push_back('{32'd0, 32'd1, 32'h0, t0 + 32'd5});
    wait_drain(20);
    m1_lock = 1'b1;
    t1 = cyc;
    for (int k = 0; k < 4; k++)
      sb.push_back('{32'd0, 32'd1, 32'h0, t1 + 32'(3 * k + 2)});
    sb.push_back('{32'd0, 32'd0, 32'h0, t1 + 32'd14});
    wait_drain(40);
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;

    // reset during a read's WAIT state abandons it and restores last_owner
    tick();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h30; m0_wen = 1'b1; m0_wdata = 32'h33;
    t0 = cyc;
    sb.push_back('{32'd0, 32'd0, 32'h0, t0 + 32'd2});
    wait_drain(10);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h40; m1_wen = 1'b0;
    t1 = cyc;
    tick();
    chk("abort_access_gnt", {30'd0, gnt}, 32'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_gnt", {30'd0, gnt}, 32'd0);
    chk("abort_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("abort_bus_wen", {31'd0, bus_wen}, 32'd0);
    chk("abort_bus_addr", bus_addr, 32'd0);
    m0_req = 1'b1; m0_addr = 32'h50; m0_wen = 1'b1; m0_wdata = 32'h55;
    sb.push_back('{32'd0, 32'd0, 32'h0, t1 + 32'd5});
    tick();
    chk("post_rst_gnt", {30'd0, gnt}, 32'd1);
    wait_drain(10);
    m0_req = 1'b0; m1_req = 1'b0;

    // READ_LAT=0: back-to-back m0 reads, data captured in the ACCESS cycle
    tick();
    z_m0_req = 1'b1; z_m0_addr = 32'h0;
    t0 = cyc;
    sb.push_back('{32'd1, 32'd0, 32'hC0DE_0000 ^ (t0 + 32'd1), t0 + 32'd2});
    tick();
    chk("z_rd0_gnt", {30'd0, z_gnt}, 32'd1);
    chk("z_rd0_addr", z_bus_addr, 32'h0);
    chk("z_rd0_wen", {31'd0, z_bus_wen}, 32'd0);
    wait_drain(10);
    z_m0_req = 1'b0;
    tick();
    z_m0_req = 1'b1; z_m0_addr = 32'h4;
    t1 = cyc;
    sb.push_back('{32'd1, 32'd0, 32'hC0DE_0000 ^ (t1 + 32'd1), t1 + 32'd2});
    tick();
    chk("z_rd1_addr", z_bus_addr, 32'h4);
    chk("z_rd1_wdata", z_bus_wdata, 32'h0);
    wait_drain(10);
    z_m0_req = 1'b0;
    tick();
    tick();
    chk("z_idle_gnt", {30'd0, z_gnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
